en_sequencer: RTL and testbench

Multi-channel power/enable sequencer. Raises a thermometer-coded set of channel enables one channel at a time on request, and lowers them one at a time in reverse order on release. Each step is spaced by a fixed number of `rtc_i` timebase pulses. It sits between the system control logic and the gated domains, and provides both the staggered turn-on and the ordered turn-off.

---
 rtl/en_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_en_sequencer.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/en_sequencer.sv
// en_sequencer: multi-channel power/enable sequencer.
//
// Raises a thermometer-coded set of channel enables one channel at a time while
// req_i is high, and lowers them one at a time in reverse order when req_i drops.
// Each channel change is spaced by STEP_TICKS rising edges of the slow timebase rtc_i.
//
// Parameters:
//   CHANNELS   - number of enable outputs (1..32)
//   STEP_TICKS - rtc_i rising edges per channel change (>= 1)
//
// Ports:
//   clk_i   - clock; all state on its rising edge
//   arst_ni - asynchronous active-low reset
//   rtc_i   - slow timebase, asynchronous to clk_i, synchronized internally
//   req_i   - 1 = power up, 0 = power down
//   en_o    - thermometer-coded enables, bit 0 rises first and falls last
//   busy_o  - high while ramping up or down
//   up_o    - high when every channel is enabled
//
// Build option:
//   EN_SEQUENCER_FAST_OFF_EN - when defined, dropping req_i clears every enable on
//   the next clock edge (emergency shutdown) instead of ramping down in order.
module en_sequencer #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned STEP_TICKS = 10
) (
  input  logic                clk_i,
  input  logic                arst_ni,
  input  logic                rtc_i,
  input  logic                req_i,
  output logic [CHANNELS-1:0] en_o,
  output logic                busy_o,
  output logic                up_o
);

  localparam int unsigned LvlW = $clog2(CHANNELS + 1);
  localparam int unsigned CntW = $clog2(STEP_TICKS + 1);
  localparam logic [LvlW-1:0] LvlMax = LvlW'(CHANNELS);
  localparam logic [CntW-1:0] CntMax = CntW'(STEP_TICKS);

  localparam logic [1:0] StOff      = 2'd0;
  localparam logic [1:0] StRampUp   = 2'd1;
  localparam logic [1:0] StOn       = 2'd2;
  localparam logic [1:0] StRampDown = 2'd3;

  // ---------------------------------------------------------------------------
  // Timebase: 2-flop synchronizer, then a registered rising-edge detector.
  // ---------------------------------------------------------------------------
  logic       rtc_q1, rtc_q2, rtc_q3;
  logic       tick_q;
  logic       armed_q;
  logic [1:0] vld_q;

  // vld_q marks when rtc_q2 holds a real sample rather than reset history; edges are
  // only counted once rtc has been seen low, so a level already high out of reset is
  // not mistaken for a rise.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rtc_q1  <= 1'b0;
      rtc_q2  <= 1'b0;
      rtc_q3  <= 1'b0;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      rtc_q1  <= rtc_i;
      rtc_q2  <= rtc_q1;
      rtc_q3  <= rtc_q2;
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_q | (vld_q[1] & ~rtc_q2);
      tick_q  <= armed_q & rtc_q2 & ~rtc_q3;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  logic [1:0]          state_q, state_d;
  logic [LvlW-1:0]     level_q, level_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CntW-1:0]     cnt_inc;
  logic                step_done;
  logic [CHANNELS-1:0] en_q, en_d;

  assign cnt_inc   = cnt_q + CntW'(1);
  assign step_done = tick_q && (cnt_inc == CntMax);

  // A req_i reversal is checked before the tick, so it wins over a step-completing tick.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StOff: begin
        if (req_i) begin
          state_d = StRampUp;
          cnt_d   = '0;
        end
      end
      StRampUp: begin
        if (!req_i) begin
          cnt_d = '0;
`ifdef EN_SEQUENCER_FAST_OFF_EN
          level_d = '0;
          state_d = StOff;
`else
          state_d = (level_q == '0) ? StOff : StRampDown;
`endif
        end else if (tick_q) begin
          if (step_done) begin
            cnt_d   = '0;
            level_d = level_q + LvlW'(1);
            if (level_d == LvlMax) state_d = StOn;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StOn: begin
        if (!req_i) begin
          cnt_d = '0;
`ifdef EN_SEQUENCER_FAST_OFF_EN
          level_d = '0;
          state_d = StOff;
`else
          state_d = StRampDown;
`endif
        end
      end
      StRampDown: begin
        if (req_i) begin
          state_d = StRampUp;
          cnt_d   = '0;
`ifdef EN_SEQUENCER_FAST_OFF_EN
        end else begin
          cnt_d   = '0;
          level_d = '0;
          state_d = StOff;
        end
`else
        end else if (tick_q) begin
          if (step_done) begin
            cnt_d   = '0;
            level_d = level_q - LvlW'(1);
            if (level_d == '0) state_d = StOff;
          end else begin
            cnt_d = cnt_inc;
          end
        end
`endif
      end
    endcase
  end

  // Enables are registered from the next level so they always form a thermometer code.
  always_comb begin
    en_d = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      en_d[i] = (i < int'(level_d));
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= StOff;
      level_q <= '0;
      cnt_q   <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
    end
  end

  assign en_o   = en_q;
  assign busy_o = (state_q == StRampUp) || (state_q == StRampDown);
  assign up_o   = (state_q == StOn);

endmodule

// File: tb/tb_en_sequencer.sv
// Self-checking bench for en_sequencer (CHANNELS=4, STEP_TICKS=3).
// rtc_i rises are scheduled as future tick events; a behavioural model of the
// sequencing rules predicts the enables, busy and up flags every cycle.
module tb_en_sequencer;

  localparam int unsigned CH = 4;
  localparam int unsigned ST = 3;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          rtc;
  logic          req;
  logic [CH-1:0] en;
  logic          busy;
  logic          up;

  en_sequencer #(
    .CHANNELS  (CH),
    .STEP_TICKS(ST)
  ) dut (
    .clk_i  (clk),
    .arst_ni(arst_n),
    .rtc_i  (rtc),
    .req_i  (req),
    .en_o   (en),
    .busy_o (busy),
    .up_o   (up)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model
  typedef enum int {MOff, MUp, MOn, MDown} mstate_e;
  mstate_e m_st;
  int      m_level;
  int      m_cnt;
  int      n_ticks = 0;
  int      edge_n  = 0;
  int      tick_edges[$];   // clock edges at which a tick is consumed
  bit      m_armed;

  // rtc generator
  bit rtc_run  = 0;
  bit rtc_rand = 0;
  int rtc_half = 4;
  int rtc_ctr  = 0;

  function automatic void model_reset();
    m_st    = MOff;
    m_level = 0;
    m_cnt   = 0;
    tick_edges.delete();
  endfunction

  function automatic void model_edge(bit tick);
    if (tick) n_ticks++;
    case (m_st)
      MOff: if (req) begin m_st = MUp; m_cnt = 0; end
      MUp: begin
        if (!req) begin
          m_cnt = 0;
`ifdef EN_SEQUENCER_FAST_OFF_EN
          m_level = 0;
          m_st    = MOff;
`else
          m_st = (m_level == 0) ? MOff : MDown;
`endif
        end else if (tick) begin
          m_cnt++;
          if (m_cnt == ST) begin
            m_cnt = 0;
            m_level++;
            if (m_level == CH) m_st = MOn;
          end
        end
      end
      MOn: begin
        if (!req) begin
          m_cnt = 0;
`ifdef EN_SEQUENCER_FAST_OFF_EN
          m_level = 0;
          m_st    = MOff;
`else
          m_st = MDown;
`endif
        end
      end
      MDown: begin
        if (req) begin
          m_st  = MUp;
          m_cnt = 0;
        end else if (tick) begin
          m_cnt++;
          if (m_cnt == ST) begin
            m_cnt = 0;
            m_level--;
            if (m_level == 0) m_st = MOff;
          end
        end
      end
      default: m_st = MOff;
    endcase
  endfunction

  function automatic logic [CH+1:0] model_outputs();
    logic [CH-1:0] e;
    e = CH'((1 << m_level) - 1);
    return {e, (m_st == MUp) || (m_st == MDown), m_st == MOn};
  endfunction

  // A rise driven in the cycle after edge N shows up as a level change at edge N+4
  // (two synchronizer stages, edge register, then the state update).
  task automatic drive_rtc();
    if (!rtc_run) return;
    rtc_ctr++;
    if (rtc_ctr >= rtc_half) begin
      rtc_ctr = 0;
      rtc     = ~rtc;
      if (rtc_rand) rtc_half = $urandom_range(2, 5);
      if (rtc) begin
        if (arst_n && m_armed) tick_edges.push_back(edge_n + 4);
      end else begin
        m_armed = 1;
      end
    end
  endtask

  task automatic step();
    bit tick;
    @(posedge clk);
    edge_n++;
    tick = 0;
    while (tick_edges.size() > 0 && tick_edges[0] < edge_n) void'(tick_edges.pop_front());
    if (tick_edges.size() > 0 && tick_edges[0] == edge_n) begin
      tick = 1;
      void'(tick_edges.pop_front());
    end
    if (!arst_n) model_reset();
    else model_edge(tick);
    #1;
    drive_rtc();
  endtask

  task automatic release_reset();
    @(negedge clk);
    arst_n  = 1;
    m_armed = !rtc;
  endtask

  task automatic test_reset();
    arst_n  = 0;
    req     = 1;
    rtc_run = 1;
    for (int i = 0; i < 24; i++) begin
      step();
      checks++;
      if ({en, busy, up} !== 6'b0)
        $display("FAIL reset_hold: en/busy/up=%b required 000000", {en, busy, up});
      else passed++;
    end
    req = 0;
    release_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({en, busy, up} !== model_outputs())
        $display("FAIL reset_idle: en/busy/up=%b required %b", {en, busy, up}, model_outputs());
      else passed++;
    end
  endtask

  task automatic test_ramp_up();
    int            t0, idx;
    bit            done;
    logic [CH-1:0] prev, exp_en;
    req = 1;
    step();
    t0   = n_ticks;
    idx  = 0;
    done = 0;
    prev = en;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      checks++;
      if ({en, busy, up} !== model_outputs())
        $display("FAIL ramp_up_cycle: en/busy/up=%b required %b", {en, busy, up}, model_outputs());
      else passed++;
      if (en !== prev) begin
        exp_en = CH'((1 << (idx + 1)) - 1);
        checks++;
        if (en !== exp_en || (n_ticks - t0) != int'(ST) * (idx + 1))
          $display("FAIL ramp_up_step: en=%b after %0d ticks, required %b after %0d",
                   en, n_ticks - t0, exp_en, int'(ST) * (idx + 1));
        else passed++;
        idx++;
        prev = en;
      end
      if (up === 1'b1) done = 1;
    end
    checks++;
    if (!done || en !== 4'b1111 || (n_ticks - t0) != int'(CH * ST))
      $display("FAIL ramp_up_done: up=%b en=%b ticks=%0d, required up=1 en=1111 ticks=%0d",
               up, en, n_ticks - t0, CH * ST);
    else passed++;
  endtask

  task automatic test_ramp_down();
    int            t0, idx;
    bit            done;
    logic [CH-1:0] prev, exp_en;
    req = 0;
    step();
    checks++;
    if (up !== 1'b0 || busy !== 1'b1 || en !== 4'b1111)
      $display("FAIL ramp_down_start: up=%b busy=%b en=%b, required 0 1 1111", up, busy, en);
    else passed++;
    t0   = n_ticks;
    idx  = 0;
    done = 0;
    prev = en;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      checks++;
      if ({en, busy, up} !== model_outputs())
        $display("FAIL ramp_down_cycle: en/busy/up=%b required %b", {en, busy, up}, model_outputs());
      else passed++;
      if (en !== prev) begin
        exp_en = CH'((1 << (int'(CH) - 1 - idx)) - 1);
        checks++;
        if (en !== exp_en || (n_ticks - t0) != int'(ST) * (idx + 1))
          $display("FAIL ramp_down_step: en=%b after %0d ticks, required %b after %0d",
                   en, n_ticks - t0, exp_en, int'(ST) * (idx + 1));
        else passed++;
        idx++;
        prev = en;
        if (en === '0) begin
          done = 1;
          checks++;
          if (busy !== 1'b0) $display("FAIL ramp_down_busy: busy=%b required 0", busy);
          else passed++;
        end
      end
    end
    checks++;
    if (!done) $display("FAIL ramp_down_timeout: en=%b required 0000 within budget", en);
    else passed++;
  endtask

  task automatic test_reversal();
    int t0, t1;
    bit ok;
    req = 1;
    step();
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      step();
      checks++;
      if ({en, busy, up} !== model_outputs())
        $display("FAIL reversal_up_cycle: en/busy/up=%b required %b", {en, busy, up}, model_outputs());
      else passed++;
      if (en === 4'b0011) ok = 1;
    end
    t0 = n_ticks;
    for (int i = 0; i < 50 && ok && n_ticks == t0; i++) step();
    req = 0;
    step();
    t1 = n_ticks;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      step();
      checks++;
      if ({en, busy, up} !== model_outputs())
        $display("FAIL reversal_down_cycle: en/busy/up=%b required %b", {en, busy, up}, model_outputs());
      else passed++;
      if (en !== 4'b0011) ok = 1;
    end
    checks++;
    if (en !== 4'b0001 || (n_ticks - t1) != int'(ST))
      $display("FAIL reversal_first: en=%b after %0d ticks, required 0001 after %0d",
               en, n_ticks - t1, ST);
    else passed++;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      step();
      if (en !== 4'b0001) ok = 1;
    end
    checks++;
    if (en !== 4'b0000 || busy !== 1'b0 || (n_ticks - t1) != int'(2 * ST))
      $display("FAIL reversal_second: en=%b busy=%b after %0d ticks, required 0000 0 after %0d",
               en, busy, n_ticks - t1, 2 * ST);
    else passed++;
  endtask

  task automatic test_reversal_on_step();
    bit ok;
    req = 1;
    step();
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      step();
      if (m_st == MUp && m_level == 2 && m_cnt == int'(ST) - 1 &&
          tick_edges.size() > 0 && tick_edges[0] == edge_n + 1) ok = 1;
    end
    checks++;
    if (!ok || en !== 4'b0011)
      $display("FAIL reversal_step_setup: en=%b, required 0011 one edge before a completing tick", en);
    else passed++;
    req = 0;
    step();
    checks++;
    if (en !== 4'b0011 || busy !== 1'b1 || up !== 1'b0)
      $display("FAIL reversal_step_hold: en=%b busy=%b up=%b, required 0011 1 0", en, busy, up);
    else passed++;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      step();
      checks++;
      if ({en, busy, up} !== model_outputs())
        $display("FAIL reversal_step_cycle: en/busy/up=%b required %b", {en, busy, up}, model_outputs());
      else passed++;
      if (m_st == MOff) ok = 1;
    end
    checks++;
    if (!ok || en !== 4'b0000) $display("FAIL reversal_step_end: en=%b required 0000", en);
    else passed++;
  endtask

`ifdef EN_SEQUENCER_FAST_OFF_EN
  task automatic test_fast_off();
    bit ok;
    req = 1;
    ok  = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      step();
      if (up === 1'b1) ok = 1;
    end
    checks++;
    if (!ok) $display("FAIL fast_off_setup: up=%b required 1 within budget", up);
    else passed++;
    req = 0;
    step();
    checks++;
    if ({en, busy, up} !== 6'b0)
      $display("FAIL fast_off: en/busy/up=%b required 000000", {en, busy, up});
    else passed++;
  endtask
`endif

  task automatic test_reset_mid_ramp();
    int t0;
    bit ok;
    req = 1;
    ok  = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      step();
      checks++;
      if ({en, busy, up} !== model_outputs())
        $display("FAIL midreset_up_cycle: en/busy/up=%b required %b", {en, busy, up}, model_outputs());
      else passed++;
      if (en === 4'b0111) ok = 1;
    end
    #1;
    arst_n  = 0;
    model_reset();
    rtc_run = 0;
    rtc     = 1;
    #1;
    checks++;
    if (!ok || {en, busy, up} !== 6'b0)
      $display("FAIL midreset_async: en/busy/up=%b required 000000 before the next edge",
               {en, busy, up});
    else passed++;
    repeat (3) step();
    release_reset();
    t0 = n_ticks;
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (en !== 4'b0000 || busy !== 1'b1 || n_ticks != t0)
      $display("FAIL midreset_no_tick: en=%b busy=%b, required 0000 1 with rtc held high", en, busy);
    else passed++;
    rtc_ctr = 0;
    rtc_run = 1;
    ok      = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      checks++;
      if ({en, busy, up} !== model_outputs())
        $display("FAIL midreset_cycle: en/busy/up=%b required %b", {en, busy, up}, model_outputs());
      else passed++;
      if (en !== 4'b0000) ok = 1;
    end
    checks++;
    if (en !== 4'b0001 || (n_ticks - t0) != int'(ST))
      $display("FAIL midreset_first_step: en=%b after %0d ticks, required 0001 after %0d",
               en, n_ticks - t0, ST);
    else passed++;
  endtask

  task automatic test_random();
    rtc_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) req = ~req;
      if ($urandom_range(0, 599) == 0) begin
        #1;
        arst_n = 0;
        model_reset();
        #1;
        checks++;
        if ({en, busy, up} !== 6'b0)
          $display("FAIL random_async_reset: en/busy/up=%b required 000000", {en, busy, up});
        else passed++;
        repeat (2) step();
        release_reset();
      end
      step();
      checks++;
      if ({en, busy, up} !== model_outputs())
        $display("FAIL random_cycle %0d: en/busy/up=%b required %b", i, {en, busy, up},
                 model_outputs());
      else passed++;
    end
  endtask

  initial begin
    arst_n  = 0;
    req     = 0;
    rtc     = 0;
    m_armed = 1;
    model_reset();
    test_reset();
    test_ramp_up();
`ifdef EN_SEQUENCER_FAST_OFF_EN
    req = 0;
    step();
    test_fast_off();
`else
    test_ramp_down();
    test_reversal();
    test_reversal_on_step();
`endif
    req = 0;
    repeat (2) step();
    test_reset_mid_ramp();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
